// File: rtl/reg_file_pkg.sv
// Shared widths and typedefs for the scoreboarded register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NRD_DEF    = 2;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, write port, claim port and status.
interface reg_file_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
);
  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       claim_en;
  logic [ADDR_W-1:0]          claim_addr;
  logic                       claim_ready;
  logic [ADDR_W:0]            busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, claim_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, claim_ready, busy_cnt
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Busy-bit tracker: a claim reserves a register until a write to it lands.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int  ADDR_W = ADDR_W_DEF,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_ready,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] busy_nxt;

  // A write retiring the current claim in the same cycle frees the slot for a new claim.
  assign claim_ready = ~busy[claim_addr] | (wr_en & (wr_addr == claim_addr));

  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[wr_addr] = 1'b0;
    if (claim_en && claim_ready)
      busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy[i]};
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register claim scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]           busy;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_file_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .claim_en    (bus.claim_en),
    .claim_addr  (bus.claim_addr),
    .claim_ready (bus.claim_ready),
    .busy        (busy),
    .busy_cnt    (bus.busy_cnt)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = mem[bus.rd_addr[p]];
      rd_busy[p] = busy[bus.rd_addr[p]];
`ifdef REG_FILE_BYPASS_EN
      // Gated by rst_n so a write presented during reset never leaks onto rd_data.
      if (rst_n && bus.wr_en && (bus.rd_addr[p] == bus.wr_addr)) begin
        rd_data[p] = bus.wr_data;
        rd_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;

endmodule
